// File: rtl/clusterv_sram_initiator_if.sv
// Command and response streams between a test master and the SRAM initiator.
// The master drives commands and consumes responses; the slave is the engine.
interface clusterv_sram_initiator_if #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 10
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_we;
  logic [ADR_WIDTH-1:0]   cmd_adr;
  logic [DAT_WIDTH/8-1:0] cmd_sel;
  logic [DAT_WIDTH-1:0]   cmd_dat;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DAT_WIDTH-1:0]   rsp_dat;

  modport master (
    output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dat
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dat
  );
endinterface

// File: rtl/clusterv_sram_initiator.sv
// SRAM initiator: one access per cycle onto a byte-enable SRAM port, read data
// captured after the fixed 1-cycle latency and returned in order via a credit-guarded FIFO.
module clusterv_sram_initiator #(
  parameter int DAT_WIDTH = 32,
  parameter int ADR_WIDTH = 10,
  parameter int RSP_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  clusterv_sram_initiator_if.slave bus,
  output logic [ADR_WIDTH-1:0]   i_addr,
  output logic                   i_write_en,
  output logic [DAT_WIDTH/8-1:0] i_byte_en,
  output logic [DAT_WIDTH-1:0]   i_write_data,
  input  logic [DAT_WIDTH-1:0]   i_read_data,
  output logic                   idle
);

  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   occ_t;

  // Issue stage (S1) doubles as the registered SRAM port.
  logic                 started_q;
  logic                 s1_valid_q, s1_rd_q;
  logic                 s2_valid_q, s2_rd_q;
  logic [ADR_WIDTH-1:0] addr_q;
  logic                 wen_q;
  logic [SEL_W-1:0]     ben_q;
  logic [DAT_WIDTH-1:0] wdata_q;

  logic [DAT_WIDTH-1:0] fifo_q [RSP_DEPTH];
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  cnt_t                 count_q, count_d;

  logic occ_ok;
  occ_t occ;
  logic accept, push, pop, fifo_empty;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(RSP_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Credits cover every read that may still land in the FIFO, so a push can
  // never find it full; rsp_ready deliberately does not feed cmd_ready.
  assign occ    = occ_t'(count_q) + occ_t'(s1_rd_q) + occ_t'(s2_rd_q);
  assign occ_ok = (occ < occ_t'(RSP_DEPTH));

  assign fifo_empty    = (count_q == '0);
  assign bus.cmd_ready = started_q && occ_ok;
  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_dat   = fifo_empty ? '0 : fifo_q[rd_ptr_q];

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign push   = s2_rd_q;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  assign i_addr       = addr_q;
  assign i_write_en   = wen_q;
  assign i_byte_en    = ben_q;
  assign i_write_data = wdata_q;
  assign idle         = !s1_valid_q && !s2_valid_q && fifo_empty;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + cnt_t'(1);
    end else if (!push && pop) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge
  // values; reset is asynchronous so the SRAM strobe drops the instant it asserts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      started_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_rd_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_rd_q    <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      ben_q      <= '0;
      wdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      started_q  <= 1'b1;
      s1_valid_q <= accept;
      s1_rd_q    <= accept && !bus.cmd_we;
      s2_valid_q <= s1_valid_q;
      s2_rd_q    <= s1_rd_q;
      wen_q      <= accept && bus.cmd_we;
      ben_q      <= (accept && bus.cmd_we) ? bus.cmd_sel : '0;
      if (accept) begin
        addr_q  <= bus.cmd_adr;
        wdata_q <= bus.cmd_dat;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; rsp_dat is masked to zero while empty,
  // so stale entries are never visible.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= i_read_data;
    end
  end

  overflow_a: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (count_q == cnt_t'(RSP_DEPTH))));

endmodule

// File: tb/tb_clusterv_sram_initiator.sv
// Randomised self-checking bench: SRAM target model plus a command-level
// reference (shadow memory and expected-response queue) checked every cycle.
module tb_clusterv_sram_initiator;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int SW    = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  clusterv_sram_initiator_if #(.DAT_WIDTH(DW), .ADR_WIDTH(AW)) bus ();

  logic [AW-1:0] i_addr;
  logic          i_write_en;
  logic [SW-1:0] i_byte_en;
  logic [DW-1:0] i_write_data;
  logic [DW-1:0] i_read_data;
  logic          idle;

  clusterv_sram_initiator #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .i_addr       (i_addr),
    .i_write_en   (i_write_en),
    .i_byte_en    (i_byte_en),
    .i_write_data (i_write_data),
    .i_read_data  (i_read_data),
    .idle         (idle)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SRAM target: writes merge by byte enable, read data appears the cycle after sampling.
  logic [DW-1:0] sram [0:2**AW-1] = '{default: '0};
  always @(posedge clock) begin
    if (i_write_en) begin
      for (int b = 0; b < SW; b++) begin
        if (i_byte_en[b]) sram[i_addr][8*b +: 8] <= i_write_data[8*b +: 8];
      end
    end
    i_read_data <= sram[i_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic started_m;
  always @(posedge clock or posedge reset) begin
    if (reset) started_m <= 1'b0;
    else       started_m <= 1'b1;
  end

  // rsp_ready driver: 0 = hold low, 1 = hold high, 2 = random.
  int rr_mode = 1;
  always @(posedge clock) begin
    #1;
    if (rr_mode == 2) bus.rsp_ready = 1'($urandom_range(0, 1));
    else              bus.rsp_ready = (rr_mode == 1);
  end

  // Reference model: memory contents as seen in command order, and the reads owed.
  typedef struct {
    logic [DW-1:0] dat;
    int            acc;
  } exp_t;

  logic [DW-1:0] shadow [0:2**AW-1] = '{default: '0};
  exp_t          exp_q [$];
  int            rsp_cyc [$];

  bit            mon_en = 0;
  bit            acc1, acc2, hold_v;
  logic [DW-1:0] hold_dat;
  bit            iss_v, iss_we;
  logic [AW-1:0] iss_adr;
  logic [SW-1:0] iss_sel;
  logic [DW-1:0] iss_dat;
  int            acc_total = 0, rsp_total = 0, wr_pulses = 0, stalls = 0;
  int            last_lat = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [DW-1:0] last_rsp = '0;

  always @(negedge clock) begin
    if (!mon_en) begin
      exp_q.delete();
      acc1 = 0; acc2 = 0; hold_v = 0; iss_v = 0; iss_we = 0;
    end else begin
      bit rv_exp;
      exp_t e;
      rv_exp = 0;
      if (exp_q.size() > 0) rv_exp = (exp_q[0].acc <= cyc - 2);
      check("cmd_ready", bus.cmd_ready, started_m && (exp_q.size() < DEPTH));
      check("rsp_valid", bus.rsp_valid, rv_exp);
      check("idle", idle, (exp_q.size() == 0) && !acc1 && !acc2);
      check("i_write_en", i_write_en, iss_v && iss_we);
      check("i_byte_en", i_byte_en, (iss_v && iss_we) ? iss_sel : '0);
      if (iss_v) check("i_addr", i_addr, iss_adr);
      if (iss_v && iss_we) check("i_write_data", i_write_data, iss_dat);
      if (i_write_en) begin
        wr_pulses++;
        last_wr_addr = i_addr;
      end
      if (hold_v && bus.rsp_valid) check("rsp_hold", bus.rsp_dat, hold_dat);

      if (bus.rsp_valid && bus.rsp_ready && exp_q.size() > 0) begin
        check("rsp_dat", bus.rsp_dat, exp_q[0].dat);
        last_lat = cyc - exp_q[0].acc;
        last_rsp = bus.rsp_dat;
        void'(exp_q.pop_front());
        rsp_total++;
        rsp_cyc.push_back(cyc);
      end
      hold_v   = bus.rsp_valid && !bus.rsp_ready;
      hold_dat = bus.rsp_dat;

      acc2    = acc1;
      acc1    = bus.cmd_valid && bus.cmd_ready;
      iss_v   = acc1;
      iss_we  = bus.cmd_we;
      iss_adr = bus.cmd_adr;
      iss_sel = bus.cmd_sel;
      iss_dat = bus.cmd_dat;
      if (acc1) begin
        acc_total++;
        if (bus.cmd_we) begin
          for (int b = 0; b < SW; b++) begin
            if (bus.cmd_sel[b]) shadow[bus.cmd_adr][8*b +: 8] = bus.cmd_dat[8*b +: 8];
          end
        end else begin
          e.dat = shadow[bus.cmd_adr];
          e.acc = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input bit we, input logic [AW-1:0] adr,
                       input logic [SW-1:0] sel, input logic [DW-1:0] dat);
    bit got;
    got = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_sel   = sel;
    bus.cmd_dat   = dat;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clock);
      got = bus.cmd_ready;
      if (!got) stalls++;
      @(posedge clock);
      #1;
    end
    if (!got) check("cmd_accept_timeout", 0, 1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clock);
      done = idle && (exp_q.size() == 0);
      @(posedge clock);
      #1;
    end
    check("drain_timeout", done, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, rbase, nreads;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_sel   = '0;
    bus.cmd_dat   = '0;

    #2;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_dat", bus.rsp_dat, 0);
    check("rst_i_addr", i_addr, 0);
    check("rst_i_write_en", i_write_en, 0);
    check("rst_i_byte_en", i_byte_en, 0);
    check("rst_i_write_data", i_write_data, 0);
    check("rst_idle", idle, 1);

    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1;
    @(posedge clock);
    #1;
    check("ready_after_reset", bus.cmd_ready, 1);

    // Write then read back.
    base = wr_pulses;
    issue(1, 10'h005, 4'hF, 32'h1234_5678);
    issue(0, 10'h005, 4'h0, 32'h0);
    wait_idle();
    check("t1_write_pulses", wr_pulses - base, 1);
    check("t1_write_addr", last_wr_addr, 10'h005);
    check("t1_rsp", last_rsp, 32'h1234_5678);
    check("t1_latency", last_lat, 2);

    // Byte-mask merge.
    issue(1, 10'h010, 4'hF, 32'hFFFF_FFFF);
    issue(1, 10'h010, 4'b0001, 32'h0000_00AA);
    issue(0, 10'h010, 4'h0, 32'h0);
    wait_idle();
    check("t2_merge", last_rsp, 32'hFFFF_FFAA);

    // Streaming reads at full rate.
    for (int a = 0; a < 16; a++) issue(1, AW'(a), 4'hF, DW'(a * 3));
    wait_idle();
    base = stalls;
    rsp_cyc.delete();
    for (int a = 0; a < 16; a++) issue(0, AW'(a), 4'h0, 32'h0);
    wait_idle();
    check("t3_no_stall", stalls - base, 0);
    check("t3_rsp_count", rsp_cyc.size(), 16);
    if (rsp_cyc.size() == 16) check("t3_consecutive", rsp_cyc[15] - rsp_cyc[0], 15);
    check("t3_last", last_rsp, 32'd45);

    // Backpressure: credits run out after DEPTH reads.
    rr_mode = 0;
    @(posedge clock);
    #1;
    base  = acc_total;
    rbase = rsp_total;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(0, AW'(i), 4'h0, 32'h0);
      end
      begin
        repeat (12) @(posedge clock);
        #1;
        check("t4_accepted_stalled", acc_total - base, DEPTH);
        check("t4_ready_low", bus.cmd_ready, 0);
        rr_mode = 1;
      end
    join
    wait_idle();
    check("t4_accepted_all", acc_total - base, 6);
    check("t4_returned_all", rsp_total - rbase, 6);

    // Wrap-around and mixed random traffic under random backpressure.
    rr_mode = 2;
    rbase   = rsp_total;
    nreads  = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      issue(0, AW'($urandom_range(0, 15)), 4'h0, 32'h0);
      nreads++;
    end
    for (int i = 0; i < 40; i++) begin
      bit we;
      we = ($urandom_range(0, 2) == 0);
      if (!we) nreads++;
      issue(we, AW'($urandom_range(0, 15)), SW'($urandom), DW'($urandom));
    end
    wait_idle();
    rr_mode = 1;
    check("t5_rsp_count", rsp_total - rbase, nreads);

    // Reset with two reads in flight and one buffered.
    issue(1, 10'h3FF, 4'hF, 32'hCAFE_F00D);
    wait_idle();
    rr_mode = 0;
    @(posedge clock);
    #1;
    issue(0, 10'h001, 4'h0, 32'h0);
    issue(0, 10'h002, 4'h0, 32'h0);
    issue(0, 10'h003, 4'h0, 32'h0);
    #1;
    mon_en = 0;
    reset  = 1'b1;
    #1;
    check("t6_rsp_valid", bus.rsp_valid, 0);
    check("t6_idle", idle, 1);
    check("t6_cmd_ready", bus.cmd_ready, 0);
    check("t6_i_write_en", i_write_en, 0);
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b0;
    mon_en  = 1;
    rr_mode = 1;
    rbase   = rsp_total;
    @(posedge clock);
    #1;
    issue(0, 10'h3FF, 4'h0, 32'h0);
    wait_idle();
    check("t6_rsp_count", rsp_total - rbase, 1);
    check("t6_rsp", last_rsp, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
